// File: rtl/gnw_input_pkg.sv
// Shared types for the joystick-to-K key matrix: config entry layout and loader FSM states.
package gnw_input_pkg;

  localparam int unsigned CfgIdxLsb  = 0;
  localparam int unsigned CfgIdxW    = 5;
  localparam int unsigned CfgInvBit  = 5;
  localparam int unsigned CfgRsvdBit = 6;
  localparam int unsigned CfgEnBit   = 7;

  // Field order follows the download byte: [7] en, [6] rsvd, [5] inv, [4:0] idx.
  typedef struct packed {
    logic       en;
    logic       rsvd;
    logic       inv;
    logic [4:0] idx;
  } cfg_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } load_state_t;

  // Bits above the configured joystick width are zero in the padded key word.
  function automatic logic cell_value(input cfg_entry_t entry, input logic [31:0] key_word);
    return entry.en & (key_word[entry.idx] ^ entry.inv);
  endfunction

endpackage

// File: rtl/gnw_debounce.sv
// Per-bit debouncer: key follows raw only after raw has differed for DEBOUNCE_CYCLES cycles.
module gnw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic key
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            key_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
      key_q <= 1'b0;
    end else if (raw == key_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
      key_q <= raw;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign key = key_q;

endmodule

// File: rtl/gnw_input_matrix.sv
// Configurable joystick-to-MCU key matrix with download-loaded cell table.
// Optional per-bit debounce is compiled in with GNW_INPUT_DEBOUNCE_EN.
module gnw_input_matrix
  import gnw_input_pkg::*;
#(
  parameter int unsigned NUM_STROBES     = 8,
  parameter int unsigned K_WIDTH         = 4,
  parameter int unsigned JOY_WIDTH       = 32,
  parameter int unsigned CFG_BASE        = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [JOY_WIDTH-1:0]   joystick,
  input  logic [NUM_STROBES-1:0] S,
  output logic [K_WIDTH-1:0]     K,
  output logic                   cfg_valid
);

  localparam int unsigned NumEntries = NUM_STROBES * K_WIDTH;
  localparam int unsigned IdxW       = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam int unsigned CntW       = $clog2(NumEntries + 1);
  localparam logic [24:0] AddrLo     = 25'(CFG_BASE);
  localparam logic [24:0] AddrHi     = 25'(CFG_BASE + NumEntries);

  load_state_t           state_q, state_d;
  cfg_entry_t            table_q [NumEntries];
  cfg_entry_t            table_d [NumEntries];
  logic [NumEntries-1:0] got_q, got_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  dl_q;
  logic                  dl_rise;
  logic                  wr_hit;
  logic [IdxW-1:0]       widx;
  logic [JOY_WIDTH-1:0]  key;
  logic [31:0]           key_ext;
  logic [NumEntries-1:0] unused_rsvd;

  assign dl_rise = ioctl_download & ~dl_q;
  assign wr_hit  = ioctl_wr && (ioctl_addr >= AddrLo) && (ioctl_addr < AddrHi);
  assign widx    = IdxW'(ioctl_addr - AddrLo);

  always_comb begin
    state_d = state_q;
    table_d = table_q;
    got_d   = got_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (dl_rise) begin
          state_d = StLoad;
          table_d = '{default: '0};
          got_d   = '0;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (wr_hit) begin
          for (int i = 0; i < NumEntries; i++) begin
            if (widx == IdxW'(i)) begin
              table_d[i] = cfg_entry_t'(ioctl_dout);
              if (!got_q[i]) begin
                got_d[i] = 1'b1;
                cnt_d    = cnt_q + 1'b1;
              end
            end
          end
        end
        // A write landing with the falling edge is already folded into cnt_d.
        if (!ioctl_download) begin
          state_d = (cnt_d == CntW'(NumEntries)) ? StRun : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= StIdle;
      table_q <= '{default: '0};
      got_q   <= '0;
      cnt_q   <= '0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      got_q   <= got_d;
      cnt_q   <= cnt_d;
      dl_q    <= ioctl_download;
    end
  end

`ifdef GNW_INPUT_DEBOUNCE_EN
  logic [JOY_WIDTH-1:0] raw_q;

  always_ff @(posedge clk_sys) begin
    if (reset) raw_q <= '0;
    else       raw_q <= joystick;
  end

  for (genvar i = 0; i < JOY_WIDTH; i++) begin : g_debounce
    gnw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_sys(clk_sys),
      .reset  (reset),
      .raw    (raw_q[i]),
      .key    (key[i])
    );
  end
`else
  logic [JOY_WIDTH-1:0] key_q;
  logic                 unused_debounce;

  always_ff @(posedge clk_sys) begin
    if (reset) key_q <= '0;
    else       key_q <= joystick;
  end

  assign key             = key_q;
  assign unused_debounce = (DEBOUNCE_CYCLES == 0);
`endif

  // S to K is purely combinational: the MCU samples K in the cycle it drives S.
  always_comb begin
    key_ext                = '0;
    key_ext[JOY_WIDTH-1:0] = key;
    K                      = '0;
    if (state_q == StRun) begin
      for (int s = 0; s < NUM_STROBES; s++) begin
        for (int b = 0; b < K_WIDTH; b++) begin
          if (S[s] && cell_value(table_q[s*K_WIDTH+b], key_ext)) K[b] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    unused_rsvd = '0;
    for (int i = 0; i < NumEntries; i++) unused_rsvd[i] = table_q[i].rsvd;
  end

  assign cfg_valid = (state_q == StRun);

endmodule

// File: tb/tb_gnw_input_matrix.sv
// Scoreboard bench for gnw_input_matrix; also exercises debounce when GNW_INPUT_DEBOUNCE_EN is set.
module tb_gnw_input_matrix;

  localparam int CfgBase   = 1;
  localparam int NEnt      = 32;
  localparam int DebCycles = 4;
`ifdef GNW_INPUT_DEBOUNCE_EN
  localparam int KeyLat = 1 + DebCycles;
`else
  localparam int KeyLat = 1;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [31:0] joystick;
  logic [7:0]  S;
  logic [3:0]  K;
  logic        cfg_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] exp;
  logic [7:0] img  [NEnt];
  logic [7:0] mtab [NEnt];
  logic [NEnt-1:0] m_got;
  logic       m_valid;

  gnw_input_matrix #(
    .NUM_STROBES    (8),
    .K_WIDTH        (4),
    .JOY_WIDTH      (32),
    .CFG_BASE       (CfgBase),
    .DEBOUNCE_CYCLES(DebCycles)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .joystick      (joystick),
    .S             (S),
    .K             (K),
    .cfg_valid     (cfg_valid)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] model_k(input logic [7:0] s, input logic [31:0] joy);
    logic [3:0] k;
    logic [7:0] e;
    k = '0;
    if (!m_valid) return k;
    for (int si = 0; si < 8; si++) begin
      for (int b = 0; b < 4; b++) begin
        e = mtab[si*4+b];
        if (s[si] && e[7] && (joy[e[4:0]] ^ e[5])) k[b] = 1'b1;
      end
    end
    return k;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_s(input logic [7:0] v);
    @(negedge clk_sys);
    S = v;
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NEnt; i++) mtab[i] = 8'h00;
    m_got   = '0;
    m_valid = 1'b0;
  endtask

  task automatic wr_byte(input int addr, input logic [7:0] data);
    ioctl_addr = 25'(addr);
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    if (addr >= CfgBase && addr < CfgBase + NEnt) begin
      mtab[addr-CfgBase]  = data;
      m_got[addr-CfgBase] = 1'b1;
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
    model_clear();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
    m_valid = &m_got;
  endtask

  // mode 0: drop download after last write; 1: drop with last write
  task automatic load_image(input int n, input int mode);
    start_dl();
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && i == n - 1) ioctl_download = 1'b0;
      wr_byte(CfgBase + i, img[i]);
    end
    if (mode == 1) m_valid = &m_got;
    else end_dl();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    S = 8'hFF;
    exp_q.push_back(8'h00);
    #1;
    exp = exp_q.pop_front();
    total++;
    if ({7'd0, cfg_valid} !== exp) begin
      bad++;
      $display("FAIL reset_cfg_valid got=%b exp=%b", cfg_valid, exp[0]);
    end
    reset = 1'b0;
    tick();
    set_s(8'hFF);
    exp_q.push_back(8'h00);
    exp = exp_q.pop_front();
    total++;
    if ({4'd0, K} !== exp) begin
      bad++;
      $display("FAIL reset_k got=%b exp=%b", K, exp[3:0]);
    end
  endtask

  task automatic test_single_cell();
    for (int i = 0; i < NEnt; i++) img[i] = 8'h00;
    img[0]   = 8'h84;
    joystick = '0;
    start_dl();
    for (int i = 0; i < NEnt; i++) wr_byte(CfgBase + i, img[i]);
    set_s(8'hFF);
    exp_q.push_back(8'h00);
    exp = exp_q.pop_front();
    total++;
    if ({3'd0, cfg_valid, K} !== exp) begin
      bad++;
      $display("FAIL load_busy valid_k got=%b%b exp=%b", cfg_valid, K, exp[4:0]);
    end
    tick();
    ioctl_download = 1'b0;
    exp_q.push_back(8'h00);
    #1;
    exp = exp_q.pop_front();
    total++;
    if ({7'd0, cfg_valid} !== exp) begin
      bad++;
      $display("FAIL valid_before_edge got=%b exp=%b", cfg_valid, exp[0]);
    end
    tick();
    m_valid = &m_got;
    exp_q.push_back(8'h01);
    exp = exp_q.pop_front();
    total++;
    if ({7'd0, cfg_valid} !== exp) begin
      bad++;
      $display("FAIL valid_after_fall got=%b exp=%b", cfg_valid, exp[0]);
    end
    tick();
    joystick[4] = 1'b1;
    S = 8'h01;
    exp_q.push_back(8'h00);
    #1;
    exp = exp_q.pop_front();
    total++;
    if ({4'd0, K} !== exp) begin
      bad++;
      $display("FAIL key_latency_k got=%b exp=%b", K, exp[3:0]);
    end
    repeat (KeyLat) tick();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] sv;
      logic [3:0] ev;
      sv = (i == 0) ? 8'h01 : (i == 1) ? 8'h02 : 8'hFF;
      ev = (i == 1) ? 4'b0000 : 4'b0001;
      set_s(sv);
      exp_q.push_back({4'd0, ev});
      exp = exp_q.pop_front();
      total++;
      if ({4'd0, K} !== exp) begin
        bad++;
        $display("FAIL single_cell S=%h got=%b exp=%b", S, K, exp[3:0]);
      end
    end
  endtask

  task automatic test_invert();
    img[5]   = 8'hA3;
    joystick = '0;
    load_image(NEnt, 0);
    repeat (KeyLat) tick();
    set_s(8'h02);
    exp_q.push_back(8'h02);
    exp = exp_q.pop_front();
    total++;
    if ({4'd0, K} !== exp) begin
      bad++;
      $display("FAIL invert_low S=%h got=%b exp=%b", S, K, exp[3:0]);
    end
    joystick[3] = 1'b1;
    repeat (KeyLat) tick();
    set_s(8'h02);
    exp_q.push_back(8'h00);
    exp = exp_q.pop_front();
    total++;
    if ({4'd0, K} !== exp) begin
      bad++;
      $display("FAIL invert_high S=%h got=%b exp=%b", S, K, exp[3:0]);
    end
  endtask

  task automatic test_multi_strobe();
    logic [7:0] sv [4];
    logic [3:0] ev [4];
    sv = '{8'h03, 8'h00, 8'h01, 8'h02};
    ev = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    joystick = 32'h0000_0018;
    repeat (KeyLat) tick();
    for (int i = 0; i < 4; i++) begin
      set_s(sv[i]);
      exp_q.push_back({4'd0, ev[i]});
      exp = exp_q.pop_front();
      total++;
      if ({4'd0, K} !== exp) begin
        bad++;
        $display("FAIL multi_strobe S=%h got=%b exp=%b", S, K, exp[3:0]);
      end
    end
  endtask

  task automatic test_partial_load();
    for (int i = 0; i < NEnt; i++) img[i] = 8'h80 | 8'($urandom_range(0, 31));
    joystick = 32'hFFFF_FFFF;
    start_dl();
    for (int i = 0; i < 20; i++) wr_byte(CfgBase + i, img[i]);
    wr_byte(CfgBase + 3, img[3]);
    wr_byte(CfgBase + NEnt, 8'hFF);
    end_dl();
    repeat (KeyLat) tick();
    for (int i = 0; i <= 8; i++) begin
      set_s((i == 8) ? 8'hFF : 8'(1 << i));
      exp_q.push_back({3'd0, m_valid, model_k(S, joystick)});
      exp = exp_q.pop_front();
      total++;
      if ({3'd0, cfg_valid, K} !== exp) begin
        bad++;
        $display("FAIL partial_load S=%h valid_k got=%b%b exp=%b", S, cfg_valid, K, exp[4:0]);
      end
    end
    load_image(NEnt, 0);
    for (int i = 0; i < 3; i++) begin
      set_s(8'($urandom));
      exp_q.push_back({3'd0, m_valid, model_k(S, joystick)});
      exp = exp_q.pop_front();
      total++;
      if ({3'd0, cfg_valid, K} !== exp) begin
        bad++;
        $display("FAIL reload S=%h valid_k got=%b%b exp=%b", S, cfg_valid, K, exp[4:0]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < NEnt; i++) img[i] = 8'($urandom);
    joystick = 32'($urandom);
    start_dl();
    for (int i = 0; i < 10; i++) wr_byte(CfgBase + i, img[i]);
    reset          = 1'b1;
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      set_s(8'hFF);
      exp_q.push_back(8'h00);
      exp = exp_q.pop_front();
      total++;
      if ({3'd0, cfg_valid, K} !== exp) begin
        bad++;
        $display("FAIL reset_mid_load valid_k got=%b%b exp=%b", cfg_valid, K, exp[4:0]);
      end
    end
    load_image(NEnt, 0);
    repeat (KeyLat) tick();
    for (int i = 0; i < 8; i++) begin
      set_s(8'(1 << i));
      exp_q.push_back({3'd0, m_valid, model_k(S, joystick)});
      exp = exp_q.pop_front();
      total++;
      if ({3'd0, cfg_valid, K} !== exp) begin
        bad++;
        $display("FAIL fresh_load S=%h valid_k got=%b%b exp=%b", S, cfg_valid, K, exp[4:0]);
      end
    end
  endtask

  task automatic test_same_cycle_fall();
    for (int i = 0; i < NEnt; i++) img[i] = 8'($urandom);
    load_image(NEnt, 1);
    exp_q.push_back({7'd0, m_valid});
    exp = exp_q.pop_front();
    total++;
    if ({7'd0, cfg_valid} !== exp) begin
      bad++;
      $display("FAIL same_cycle_fall got=%b exp=%b", cfg_valid, exp[0]);
    end
    set_s(8'hFF);
    exp_q.push_back({4'd0, model_k(S, joystick)});
    exp = exp_q.pop_front();
    total++;
    if ({4'd0, K} !== exp) begin
      bad++;
      $display("FAIL same_cycle_fall_k got=%b exp=%b", K, exp[3:0]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NEnt; i++) img[i] = 8'($urandom);
      load_image(NEnt, 0);
      for (int j = 0; j < 6; j++) begin
        joystick = 32'($urandom);
        repeat (KeyLat) tick();
        set_s(8'($urandom));
        exp_q.push_back({4'd0, model_k(S, joystick)});
        exp = exp_q.pop_front();
        total++;
        if ({4'd0, K} !== exp) begin
          bad++;
          $display("FAIL random r=%0d S=%h joy=%h got=%b exp=%b", r, S, joystick, K, exp[3:0]);
        end
      end
    end
  endtask

`ifdef GNW_INPUT_DEBOUNCE_EN
  task automatic test_debounce();
    for (int i = 0; i < NEnt; i++) img[i] = 8'h00;
    img[0]   = 8'h84;
    joystick = '0;
    load_image(NEnt, 0);
    repeat (KeyLat + 1) tick();
    S = 8'h01;
    joystick[4] = 1'b1;
    repeat (3) tick();
    joystick[4] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_q.push_back(8'h00);
      exp = exp_q.pop_front();
      total++;
      if ({4'd0, K} !== exp) begin
        bad++;
        $display("FAIL debounce_pulse cyc=%0d got=%b exp=%b", i, K, exp[3:0]);
      end
    end
    joystick[4] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_q.push_back((i == 5) ? 8'h01 : 8'h00);
      exp = exp_q.pop_front();
      total++;
      if ({4'd0, K} !== exp) begin
        bad++;
        $display("FAIL debounce_hold cyc=%0d got=%b exp=%b", i, K, exp[3:0]);
      end
    end
  endtask
`endif

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    joystick       = '0;
    S              = '0;
    model_clear();
    test_reset();
    test_single_cell();
    test_invert();
    test_multi_strobe();
    test_partial_load();
    test_reset_mid_load();
    test_same_cycle_fall();
    test_random();
`ifdef GNW_INPUT_DEBOUNCE_EN
    test_debounce();
`endif
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
